// File: rtl/rv32e_prog_loader.sv
// Byte-serial program loader: receives length, instruction words and an optional checksum
// (LOADER_CHECKSUM_EN) into program RAM, holding the CPU in reset until the image is complete.
module rv32e_prog_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  reload,
  input  logic [31:0]           program_addr_bus,
  output logic [31:0]           program_data_bus,
  output logic                  cpu_reset,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHK, RUN, ERROR} state_t;
  localparam state_t LOAD_DONE = CHK;
`else
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, RUN, ERROR} state_t;
  localparam state_t LOAD_DONE = RUN;
`endif

  state_t       state, state_nxt;
  logic [7:0]   len_lo_q;
  logic [15:0]  len_q;
  logic [15:0]  len_full;
  logic [1:0]   byte_cnt;
  logic [23:0]  word_buf;
  logic         accept;
  logic         word_done;
  logic         last_word;
  logic         idle_state;
  logic [31:0]  ram [DEPTH];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]   csum;
`endif

  // Address bits [1:0] are byte offsets within a word and play no part in the fetch.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^program_addr_bus[1:0];

`ifdef LOADER_CHECKSUM_EN
  assign rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHK);
`else
  assign rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
`endif

  assign error      = (state == ERROR);
  assign idle_state = (state == RUN) || (state == ERROR);
  assign accept     = rx_valid && rx_ready;
  assign len_full   = {rx_data, len_lo_q};
  assign word_done  = accept && (state == DATA) && (byte_cnt == 2'd3);
  assign last_word  = (32'(words_loaded) + 32'd1) == 32'(len_q);

  always_comb begin
    state_nxt = state;
    case (state)
      LEN_LO: if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (32'(len_full) > 32'(DEPTH))  state_nxt = ERROR;
          else if (len_full == 16'd0)      state_nxt = LOAD_DONE;
          else                             state_nxt = DATA;
        end
      end
      DATA: if (word_done && last_word) state_nxt = LOAD_DONE;
`ifdef LOADER_CHECKSUM_EN
      CHK: if (accept) state_nxt = (rx_data == csum) ? RUN : ERROR;
`endif
      RUN, ERROR: if (reload) state_nxt = LEN_LO;
      default: state_nxt = LEN_LO;
    endcase
  end

  // Control state: state register, counters, checksum and the registered CPU reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LEN_LO;
      cpu_reset    <= 1'b1;
      words_loaded <= '0;
      byte_cnt     <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      cpu_reset <= (state_nxt != RUN);
      if (reload && idle_state) begin
        words_loaded <= '0;
        byte_cnt     <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= 8'd0;
`endif
      end else if (accept) begin
        if (state == DATA) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) words_loaded <= words_loaded + 1'b1;
        end
`ifdef LOADER_CHECKSUM_EN
        if (state != CHK) csum <= csum ^ rx_data;
`endif
      end
    end
  end

  // Datapath: length capture, little-endian word assembly and RAM write (never cleared).
  always_ff @(posedge clk) begin
    if (accept && (state == LEN_LO)) len_lo_q <= rx_data;
    if (accept && (state == LEN_HI)) len_q    <= len_full;
    if (accept && (state == DATA)) begin
      case (byte_cnt)
        2'd0:    word_buf[7:0]   <= rx_data;
        2'd1:    word_buf[15:8]  <= rx_data;
        2'd2:    word_buf[23:16] <= rx_data;
        default: ;
      endcase
    end
    if (word_done) ram[words_loaded[ADDR_WIDTH-1:0]] <= {rx_data, word_buf};
  end

  // Fetches outside the RAM window return a NOP (addi x0,x0,0).
  always_comb begin
    if (program_addr_bus[31:ADDR_WIDTH+2] == '0)
      program_data_bus = ram[program_addr_bus[ADDR_WIDTH+1:2]];
    else
      program_data_bus = 32'h0000_0013;
  end

endmodule

// File: tb/tb_rv32e_prog_loader.sv
// Directed bench for rv32e_prog_loader: per-cycle vector table plus reset/fetch sequences.
module tb_rv32e_prog_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          reload;
  logic [31:0]   program_addr_bus;
  logic [31:0]   program_data_bus;
  logic          cpu_reset;
  logic          error;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int failures = 0;

  rv32e_prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .program_addr_bus(program_addr_bus), .program_data_bus(program_data_bus),
    .cpu_reset(cpu_reset), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    logic        r;
    logic        cr;
    logic        e;
    logic [AW:0] wl;
  } row_t;

  row_t rows[$];

  task automatic add(input logic v, input logic [7:0] d, input logic rl,
                     input logic r, input logic cr, input logic e, input int wl);
    row_t x;
    x.v = v; x.d = d; x.rl = rl; x.r = r; x.cr = cr; x.e = e; x.wl = wl[AW:0];
    rows.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string nm, input logic r, input logic cr, input logic e, input int wl);
    chk({nm, ".rx_ready"}, {31'd0, rx_ready}, {31'd0, r});
    chk({nm, ".cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
    chk({nm, ".error"}, {31'd0, error}, {31'd0, e});
    chk({nm, ".words_loaded"}, 32'(words_loaded), wl);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic fetch(input string nm, input logic [31:0] a, input logic [31:0] exp);
    program_addr_bus = a;
    #1;
    chk(nm, program_data_bus, exp);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; reload = 1'b0; program_addr_bus = 32'd0;

    // Stream A: two words, then ignored traffic in RUN, then reload.
    add(1, 8'h02, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 0, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0);   // reload while loading is ignored
    add(1, 8'h13, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 0, 1);
    add(1, 8'h93, 0, 1, 1, 0, 1);
    add(1, 8'h00, 0, 1, 1, 0, 1);
    add(1, 8'h10, 0, 1, 1, 0, 1);
`ifdef LOADER_CHECKSUM_EN
    add(1, 8'h00, 0, 1, 1, 0, 2);
    add(1, 8'h92, 0, 0, 0, 0, 2);   // 02^13^93^10
`else
    add(1, 8'h00, 0, 0, 0, 0, 2);
`endif
    add(1, 8'hFF, 0, 0, 0, 0, 2);
    add(1, 8'h55, 0, 0, 0, 0, 2);
    add(0, 8'h00, 1, 1, 1, 0, 0);
    // Oversized length 257 -> ERROR, rx ignored there, reload clears it.
    add(1, 8'h01, 0, 1, 1, 0, 0);
    add(1, 8'h01, 0, 0, 1, 1, 0);
    add(1, 8'h77, 0, 0, 1, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    // Bad checksum on a one-word image.
    add(1, 8'h01, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 0, 0);
    add(1, 8'h13, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 0, 1);
    add(1, 8'h13, 0, 0, 1, 1, 1);   // correct value would be 01^13 = 12
    add(0, 8'h00, 1, 1, 1, 0, 0);
`endif
    // Zero length.
    add(1, 8'h00, 0, 1, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    add(1, 8'h00, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0);
`else
    add(1, 8'h00, 0, 0, 0, 0, 0);
`endif

    @(negedge clk);
    @(negedge clk);
    chk_ctrl("reset_state", 1, 1, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_ctrl("post_reset", 1, 1, 0, 0);

    for (int i = 0; i < rows.size(); i++) begin
      rx_valid = rows[i].v; rx_data = rows[i].d; reload = rows[i].rl;
      @(negedge clk);
      chk_ctrl($sformatf("row%0d", i), rows[i].r, rows[i].cr, rows[i].e, 32'(rows[i].wl));
    end
    rx_valid = 1'b0; reload = 1'b0;

    // RAM contents survive a zero-length reload; out-of-window fetch returns NOP.
    fetch("fetch_0", 32'h0000_0000, 32'h0000_0013);
    fetch("fetch_4", 32'h0000_0004, 32'h0010_0093);
    fetch("fetch_7", 32'h0000_0007, 32'h0010_0093);
    fetch("fetch_400", 32'h0000_0400, 32'h0000_0013);
    fetch("fetch_hi", 32'h8000_0004, 32'h0000_0013);

    // Asynchronous reset from RUN takes effect before any clock edge.
    #1 reset = 1'b1;
    #1 chk_ctrl("async_reset_run", 1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-word: two of four data bytes, then a full one-word load.
    send(8'h01); send(8'h00); send(8'hEE); send(8'hEE);
    chk_ctrl("mid_word", 1, 1, 0, 0);
    #1 reset = 1'b1;
    #1 chk_ctrl("mid_word_reset", 1, 1, 0, 0);
    fetch("no_partial_write", 32'h0000_0000, 32'h0000_0013);
    @(negedge clk);
    reset = 1'b0;
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`ifdef LOADER_CHECKSUM_EN
    send(8'h01);                     // 01^AA^BB^CC^DD
`endif
    chk_ctrl("reload_word", 0, 0, 0, 1);
    fetch("word_le", 32'h0000_0000, 32'hDDCC_BBAA);
    fetch("word1_kept", 32'h0000_0004, 32'h0010_0093);

    // Reload from RUN re-enables the receiver on the next cycle.
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk_ctrl("reload_run", 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
